md_unit: RTL and testbench

Iterative signed multiply/divide unit in the EX stage, alongside the single-cycle ALU. Triggered by the IDEX function-code multiDiv field. Returns a 16-bit primary result to the ALU result path, and a 16-bit secondary result (high product or remainder) to the R0 forwarding path. Holds a stall request to the hazard logic until the operation completes.

---
 rtl/md_pkg.sv | 24 ++
 rtl/md_if.sv | 32 +++
 rtl/md_shift_core.sv | 95 +++++++++
 rtl/md_unit.sv | 187 ++++++++++++++++++
 tb/tb_md_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// md_unit shared types: FSM states, op codes, operation kinds.
// Divide support is gated by the MD_DIV_EN macro.
package md_pkg;

    localparam int MD_WIDTH = 16;

    localparam logic [1:0] MD_OP_MUL = 2'b00;
    localparam logic [1:0] MD_OP_DIV = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } md_state_e;

    typedef enum logic [1:0] {
        K_MUL,
        K_DIV,
        K_DBZ,
        K_ILL
    } md_kind_e;

endpackage

// File: rtl/md_if.sv
// Request/response bundle between IDEX and the multiply/divide unit.
// The slave side is the md_unit; the master side is the pipeline.
interface md_if import md_pkg::*; #(
    parameter int WIDTH = MD_WIDTH
);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             stall_req;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] r0;
    logic             dbz;
    logic             ovf;

    modport master (
        output start, op, a, b, flush,
        input  stall_req, busy, done,
        input  result, r0, dbz, ovf
    );

    modport slave (
        input  start, op, a, b, flush,
        output stall_req, busy, done,
        output result, r0, dbz, ovf
    );

endinterface

// File: rtl/md_shift_core.sv
// Per-iteration shift-add multiply / restoring divide datapath.
// The divide path and partial remainder exist only with MD_DIV_EN.
module md_shift_core import md_pkg::*; #(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               step,
`ifdef MD_DIV_EN
    input  logic               is_div,
    output logic [WIDTH-1:0]   rem,
`endif
    input  logic [WIDTH-1:0]   lo_in,
    input  logic [WIDTH-1:0]   m_in,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     sum;

`ifdef MD_DIV_EN
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH+1:0]   shl;
    logic [WIDTH+1:0]   diff;
`endif

    always_comb begin
        sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (acc_q[0] ? {1'b0, m_q} : '0);
`ifdef MD_DIV_EN
        shl  = {rem_q, acc_q[WIDTH-1]};
        diff = shl - {2'b00, m_q};
`endif
    end

    always_comb begin
        acc_d = acc_q;
        m_d   = m_q;
        cnt_d = cnt_q;
`ifdef MD_DIV_EN
        rem_d = rem_q;
`endif
        if (load) begin
            acc_d = {{WIDTH{1'b0}}, lo_in};
            m_d   = m_in;
            cnt_d = '0;
`ifdef MD_DIV_EN
            rem_d = '0;
`endif
        end else if (step) begin
            cnt_d = cnt_q + CW'(1);
            acc_d = {sum, acc_q[WIDTH-1:1]};
`ifdef MD_DIV_EN
            // a borrow out of the trial subtract restores the shifted value
            if (is_div) begin
                rem_d = diff[WIDTH+1] ? shl[WIDTH:0] : diff[WIDTH:0];
                acc_d = {acc_q[2*WIDTH-1:WIDTH],
                         acc_q[WIDTH-2:0],
                         ~diff[WIDTH+1]};
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q <= '0;
            m_q   <= '0;
            cnt_q <= '0;
`ifdef MD_DIV_EN
            rem_q <= '0;
`endif
        end else begin
            acc_q <= acc_d;
            m_q   <= m_d;
            cnt_q <= cnt_d;
`ifdef MD_DIV_EN
            rem_q <= rem_d;
`endif
        end
    end

    assign acc  = acc_q;
    assign last = (cnt_q == CW'(WIDTH - 1));
`ifdef MD_DIV_EN
    assign rem  = rem_q[WIDTH-1:0];
`endif

endmodule

// File: rtl/md_unit.sv
// Iterative signed multiply/divide unit: FSM, signs, fixup, outputs.
// Divide is compiled in only when MD_DIV_EN is defined.
module md_unit import md_pkg::*; #(
    parameter int WIDTH = MD_WIDTH
) (
    input logic  clk,
    input logic  reset_n,
    md_if.slave  bus
);

    md_state_e        state_q, state_d;
    md_kind_e         kind_q, kind_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [WIDTH-1:0] araw_q, araw_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] r0_q, r0_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic               load, step, last;
    logic               op_mul, op_div, op_dbz;
    logic [WIDTH-1:0]   amag, bmag;
    logic [WIDTH-1:0]   lo_in, m_in;
    logic [2*WIDTH-1:0] acc, prod;
    logic               neg;

`ifdef MD_DIV_EN
    logic [WIDTH-1:0]   rem, qmag, q_s, r_s;
`endif

    always_comb begin
        amag   = bus.a[WIDTH-1] ? -bus.a : bus.a;
        bmag   = bus.b[WIDTH-1] ? -bus.b : bus.b;
        op_mul = (bus.op == MD_OP_MUL);
`ifdef MD_DIV_EN
        op_div = (bus.op == MD_OP_DIV) && (|bus.b);
        op_dbz = (bus.op == MD_OP_DIV) && !(|bus.b);
        lo_in  = (bus.op == MD_OP_DIV) ? amag : bmag;
        m_in   = (bus.op == MD_OP_DIV) ? bmag : amag;
`else
        op_div = 1'b0;
        op_dbz = 1'b0;
        lo_in  = bmag;
        m_in   = amag;
`endif
        neg  = sa_q ^ sb_q;
        prod = neg ? -acc : acc;
`ifdef MD_DIV_EN
        qmag = acc[WIDTH-1:0];
        q_s  = neg ? -qmag : qmag;
        r_s  = sa_q ? -rem : rem;
`endif
    end

    md_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .step    (step),
`ifdef MD_DIV_EN
        .is_div  (kind_q == K_DIV),
        .rem     (rem),
`endif
        .lo_in   (lo_in),
        .m_in    (m_in),
        .acc     (acc),
        .last    (last)
    );

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        araw_d   = araw_q;
        result_d = result_q;
        r0_d     = r0_q;
        dbz_d    = dbz_q;
        ovf_d    = ovf_q;
        load     = 1'b0;
        step     = 1'b0;

        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (bus.start) begin
                    sa_d   = bus.a[WIDTH-1];
                    sb_d   = bus.b[WIDTH-1];
                    araw_d = bus.a;
                    unique case (1'b1)
                        op_mul: begin
                            kind_d  = K_MUL;
                            load    = 1'b1;
                            state_d = CALC;
                        end
                        op_div: begin
                            kind_d  = K_DIV;
                            load    = 1'b1;
                            state_d = CALC;
                        end
                        op_dbz: begin
                            kind_d  = K_DBZ;
                            state_d = FIXUP;
                        end
                        default: begin
                            kind_d  = K_ILL;
                            state_d = FIXUP;
                        end
                    endcase
                end
                CALC: begin
                    step = 1'b1;
                    if (last) state_d = FIXUP;
                end
                FIXUP: begin
                    state_d = DONE;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    unique case (kind_q)
                        K_MUL: begin
                            result_d = prod[WIDTH-1:0];
                            r0_d     = prod[2*WIDTH-1:WIDTH];
                            ovf_d    = prod[2*WIDTH-1:WIDTH]
                                    != {WIDTH{prod[WIDTH-1]}};
                        end
`ifdef MD_DIV_EN
                        // only -2^(W-1) / -1 yields a positive 2^(W-1)
                        K_DIV: begin
                            result_d = q_s;
                            r0_d     = r_s;
                            ovf_d    = ~neg & qmag[WIDTH-1];
                        end
`endif
                        K_DBZ: begin
                            result_d = '1;
                            r0_d     = araw_q;
                            dbz_d    = 1'b1;
                        end
                        default: begin
                            result_d = '0;
                            r0_d     = '0;
                        end
                    endcase
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            kind_q   <= K_MUL;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            araw_q   <= '0;
            result_q <= '0;
            r0_q     <= '0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            araw_q   <= araw_d;
            result_q <= result_d;
            r0_q     <= r0_d;
            dbz_q    <= dbz_d;
            ovf_q    <= ovf_d;
        end
    end

    // DONE releases the stall so IDEX advances on the edge leaving it
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.stall_req = (state_q == CALC) || (state_q == FIXUP)
                        || (bus.start && (state_q == IDLE));
    assign bus.result    = result_q;
    assign bus.r0        = r0_q;
    assign bus.dbz       = dbz_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_md_unit.sv
// Randomized self-checking bench for md_unit against an arithmetic model.
// Expectations follow MD_DIV_EN the same way the design does.
module tb_md_unit;
    import md_pkg::*;

    localparam int W = MD_WIDTH;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    md_if #(.WIDTH(W)) bus();

    md_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] e_res, e_r0;
    logic        e_dbz, e_ovf;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [1:0] op,
                         input logic [15:0] a,
                         input logic [15:0] b,
                         output int lat);
        int sa, sb, p, q, r;
        sa = $signed(a);
        sb = $signed(b);
        e_res = 16'h0; e_r0 = 16'h0; e_dbz = 1'b0; e_ovf = 1'b0;
        lat = 2;
        if (op == 2'b00) begin
            p = sa * sb;
            e_res = p[15:0];
            e_r0  = p[31:16];
            e_ovf = (p < -32768) || (p > 32767);
            lat   = W + 2;
        end
`ifdef MD_DIV_EN
        else if (op == 2'b01) begin
            if (b == 16'h0) begin
                e_res = 16'hFFFF;
                e_r0  = a;
                e_dbz = 1'b1;
            end else begin
                q = sa / sb;
                r = sa % sb;
                e_res = q[15:0];
                e_r0  = r[15:0];
                e_ovf = (q > 32767);
                lat   = W + 2;
            end
        end
`endif
    endtask

    task automatic run_op(input logic [1:0] op,
                          input logic [15:0] a,
                          input logic [15:0] b,
                          input string tag);
        int lat, n;
        model(op, a, b, lat);
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        #1;
        check({tag, "/stall_at_start"}, bus.stall_req, 1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, "/busy"}, bus.busy, 1);
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "/latency"}, n + 1, lat);
        check({tag, "/result"}, bus.result, e_res);
        check({tag, "/r0"}, bus.r0, e_r0);
        check({tag, "/dbz"}, bus.dbz, e_dbz);
        check({tag, "/ovf"}, bus.ovf, e_ovf);
        check({tag, "/stall_in_done"}, bus.stall_req, 0);
        @(posedge clk); #1;
        check({tag, "/idle_after"}, bus.busy, 0);
    endtask

    function automatic logic [15:0] pick();
        logic [15:0] v;
        case ($urandom_range(0, 7))
            0: v = 16'h8000;
            1: v = 16'hFFFF;
            2: v = 16'h0001;
            3: v = 16'h7FFF;
            4: v = 16'h0000;
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        logic [1:0] rop;
        bus.start = 1'b0; bus.flush = 1'b0;
        bus.op = 2'b00; bus.a = 16'h0; bus.b = 16'h0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst/result", bus.result, 0);
        check("rst/r0", bus.r0, 0);
        check("rst/dbz", bus.dbz, 0);
        check("rst/ovf", bus.ovf, 0);
        check("rst/busy", bus.busy, 0);
        check("rst/done", bus.done, 0);
        check("rst/stall", bus.stall_req, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'b00, 16'h0007, 16'hFFFD, "mul_7x-3");
        run_op(2'b00, 16'h0100, 16'h0100, "mul_ovf");
        run_op(2'b00, 16'h8000, 16'h8000, "mul_min2");
        run_op(2'b01, 16'hFFF9, 16'h0002, "div_-7/2");
        run_op(2'b01, 16'h1234, 16'h0000, "div_by0");
        run_op(2'b01, 16'h8000, 16'hFFFF, "div_min/-1");
        run_op(2'b01, 16'h0007, 16'hFFFE, "div_7/-2");
        run_op(2'b10, 16'h1111, 16'h2222, "illegal2");
        run_op(2'b11, 16'h1111, 16'h0000, "illegal3");

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 4) >> 1);
            run_op(rop, pick(), pick(), $sformatf("rnd%0d", i));
        end

        run_op(2'b00, 16'h0123, 16'h0456, "pre_flush");
        bus.op = 2'b00; bus.a = 16'h1111; bus.b = 16'h2222;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush/busy", bus.busy, 0);
        check("flush/stall", bus.stall_req, 0);
        check("flush/result", bus.result, e_res);
        check("flush/r0", bus.r0, e_r0);
        check("flush/ovf", bus.ovf, e_ovf);
        ndone = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        check("flush/no_done", ndone, 0);

        bus.op = 2'b00; bus.a = 16'h0005; bus.b = 16'h0005;
        bus.start = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_start/busy", bus.busy, 0);

        run_op(2'b00, 16'h0100, 16'h0100, "pre_reset");
        bus.op = 2'b00; bus.a = 16'h0033; bus.b = 16'h0044;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("midrst/result", bus.result, 0);
        check("midrst/r0", bus.r0, 0);
        check("midrst/ovf", bus.ovf, 0);
        check("midrst/dbz", bus.dbz, 0);
        check("midrst/busy", bus.busy, 0);
        run_op(2'b00, 16'hFFFF, 16'hFFFF, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
